stack_lifo: RTL and testbench
=============================

STACK_LIFO -- requirements
Module: stack_lifo

Interface
REQ-001 Parameter data_width, default 8: width of each stacked word.
REQ-002 Parameter addr_width, default 4: depth is 2**addr_width entries.
REQ-003 Parameter af_level, default 2**addr_width-2: almost_full asserts when count >= af_level.
REQ-004 Parameter ae_level, default 1: almost_empty asserts when count <= ae_level.
REQ-005 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 Port rst  in  1  reset, synchronous and active-high.
REQ-007 Port clear  in  1  synchronous flush of stack contents and error flags.
REQ-008 Port push  in  1  request to push data_in.
REQ-009 Port pop  in  1  request to pop the top entry.
REQ-010 Port data_in  in  data_width  word to push.
REQ-011 Port data_out  out  data_width  registered popped word.
REQ-012 Port out_valid  out  1  one-cycle pulse; data_out updated by an accepted pop.
REQ-013 Port top  out  data_width  combinational view of the current top entry; 0 when empty.
REQ-014 Port count  out  addr_width+1  number of stored entries, 0..2**addr_width.
REQ-015 Port full, empty, almost_full, almost_empty  out  1 each  status decoded from count.
REQ-016 Port overflow, underflow  out  1 each  sticky error flags.

Function
REQ-017 Priority per cycle SHALL be rst > clear > push/pop.
REQ-018 full SHALL equal (count == 2**addr_width) and empty SHALL equal (count == 0), both derived from registered count, with no separate status state.
REQ-019 Push alone, not full: mem[count] <= data_in; count+1 at the next edge.
REQ-020 Push alone, full: rejected; memory and count unchanged; overflow set.
REQ-021 Pop alone, not empty: data_out <= mem[count-1]; out_valid=1 for the following cycle; count-1.
REQ-022 Pop alone, empty: rejected; data_out held; out_valid=0; underflow set.
REQ-023 Push+pop, not empty (including full): replace; data_out <= old top; out_valid=1; mem[count-1] <= data_in; count unchanged; no error.
REQ-024 Push+pop, empty: push accepted per REQ-019; pop rejected; underflow set.
REQ-025 out_valid SHALL be 0 in every cycle not following an accepted pop.
REQ-026 top SHALL reflect a write in the cycle after the write edge.
REQ-027 clear: count <= 0; overflow/underflow <= 0; out_valid <= 0; data_out held; memory contents are don't-care.
REQ-028 overflow/underflow SHALL stay set until rst or clear.
REQ-029 count arithmetic SHALL be addr_width+1 bits; no wrap past 0 or 2**addr_width under any input sequence.

Reset
REQ-030 On rst: count=0, empty=1, full=0, almost_empty=1, almost_full=0, out_valid=0, data_out=0, overflow=0, underflow=0.
REQ-031 Memory SHALL NOT be reset; top SHALL read 0 while empty.
REQ-032 rst asserted during any push/pop cycle SHALL discard that operation entirely.

Structure
REQ-033 A shared package stack_pkg SHALL hold the default-parameter constants and the op-decode enumeration {NOP, PUSH, POP, REPLACE}.
REQ-034 Storage SHALL be one sub-module stack_ram: a 1-write, 1-async-read register array with no reset.
REQ-035 Control and counter logic SHALL remain in stack_lifo.

Verification (data_width=8, addr_width=2, af_level=3, ae_level=1)
REQ-036 Reset, then push 0x11,0x22,0x33,0x44 -> count=4, full=1, almost_full=1, top=0x44.
REQ-037 Pop four times from that state -> data_out 0x44,0x33,0x22,0x11, each with a 1-cycle out_valid; then empty=1, count=0.
REQ-038 Push on full, then pop on empty -> overflow=1, then underflow=1; both stay high until clear pulse, then 0.
REQ-039 Stack holds 0x11,0x22; push+pop with data_in=0xAA -> data_out=0x22, out_valid=1, count=2, top=0xAA.
REQ-040 Empty, push+pop with data_in=0x55 -> count=1, top=0x55, out_valid=0, underflow=1.
REQ-041 Assert rst during a push with count=3 -> next cycle count=0, empty=1, no out_valid.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: default parameter values and the
// per-cycle operation decode used by the control logic.
package stack_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_AE_LEVEL   = 1;

    // Operation actually performed on the stack in a given cycle, after
    // rejecting pushes on full and pops on empty.
    typedef enum logic [1:0] {
        NOP,
        PUSH,
        POP,
        REPLACE
    } op_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: register array with one synchronous write port and one
// asynchronous read port. Contents are never reset.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data at raddr
module stack_ram
    import stack_pkg::*;
#(
    parameter int unsigned data_width = DEF_DATA_WIDTH,
    parameter int unsigned addr_width = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [0:(2**addr_width)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_lifo.sv
// LIFO stack with registered pop data, combinational top-of-stack view,
// count-derived status flags and sticky overflow/underflow error flags.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   clear          - synchronous flush of count and error flags
//   push, data_in  - push request and word
//   pop            - pop request
//   data_out       - registered popped word, valid when out_valid pulses
//   top            - current top entry (0 when empty)
//   count          - number of stored entries
//   full, empty, almost_full, almost_empty - status from count
//   overflow, underflow - sticky error flags
module stack_lifo
    import stack_pkg::*;
#(
    parameter int unsigned data_width = DEF_DATA_WIDTH,
    parameter int unsigned addr_width = DEF_ADDR_WIDTH,
    parameter int unsigned af_level   = (2**addr_width) - 2,
    parameter int unsigned ae_level   = DEF_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [data_width-1:0] data_in,
    output logic [data_width-1:0] data_out,
    output logic                  out_valid,
    output logic [data_width-1:0] top,
    output logic [addr_width:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [addr_width:0] FULL_CNT = (addr_width+1)'(2**addr_width);
    localparam logic [addr_width:0] AF_CNT   = (addr_width+1)'(af_level);
    localparam logic [addr_width:0] AE_CNT   = (addr_width+1)'(ae_level);

    op_e                   op;
    logic                  ovf_evt;
    logic                  udf_evt;
    logic                  we;
    logic [addr_width-1:0] waddr;
    logic [addr_width-1:0] top_addr;
    logic [data_width-1:0] rdata;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // Decode the operation that is actually carried out. A push+pop on an
    // empty stack degrades to a plain push; the pop half is flagged below.
    always_comb begin
        op = NOP;
        if (push && pop) begin
            op = empty ? PUSH : REPLACE;
        end else if (push) begin
            op = full ? NOP : PUSH;
        end else if (pop) begin
            op = empty ? NOP : POP;
        end
    end

    assign ovf_evt = push && !pop && full;
    assign udf_evt = pop && empty;

    // Top entry lives at count-1; when empty this wraps but top is masked.
    assign top_addr = addr_width'(count - 1'b1);
    assign waddr    = (op == PUSH) ? addr_width'(count) : top_addr;
    assign we       = !rst && !clear && ((op == PUSH) || (op == REPLACE));
    assign top      = empty ? '0 : rdata;

    stack_ram #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (data_in),
        .raddr (top_addr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | ovf_evt;
            underflow <= underflow | udf_evt;
            out_valid <= (op == POP) || (op == REPLACE);
            case (op)
                PUSH: begin
                    count <= count + 1'b1;
                end
                POP: begin
                    count    <= count - 1'b1;
                    data_out <= rdata;
                end
                REPLACE: begin
                    data_out <= rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_lifo.sv
module tb_stack_lifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       out_valid;
    logic [7:0] top;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_lifo #(
        .data_width (8),
        .addr_width (2),
        .af_level   (3),
        .ae_level   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .top          (top),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    typedef struct {
        logic       rst;
        logic       clr;
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic [2:0] cnt;
        logic [7:0] top;
        logic [7:0] dout;
        logic       ov;
        logic [3:0] flags;  // {full, empty, almost_full, almost_empty}
        logic [1:0] err;    // {overflow, underflow}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic c, input logic pu, input logic po,
                       input logic [7:0] d, input logic [2:0] n, input logic [7:0] t,
                       input logic [7:0] dq, input logic v, input logic [3:0] f,
                       input logic [1:0] e);
        vec_t x;
        x.rst = r; x.clr = c; x.push = pu; x.pop = po; x.din = d;
        x.cnt = n; x.top = t; x.dout = dq; x.ov = v; x.flags = f; x.err = e;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic pu, input logic po,
                        input logic [7:0] d);
        rst = r; clear = c; push = pu; pop = po; data_in = d;
        @(posedge clk);
        #1;
        rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    logic [7:0] model[$];
    logic       exp_ovf;
    logic [7:0] exp_dout;

    initial begin
        //   rst clr psh pop din   | cnt top    dout   ov flags    err
        add(1, 0, 0, 0, 8'h00,  3'd0, 8'h00, 8'h00, 0, 4'b0101, 2'b00); // 0 reset
        add(0, 0, 1, 0, 8'h11,  3'd1, 8'h11, 8'h00, 0, 4'b0001, 2'b00);
        add(0, 0, 1, 0, 8'h22,  3'd2, 8'h22, 8'h00, 0, 4'b0000, 2'b00);
        add(0, 0, 1, 0, 8'h33,  3'd3, 8'h33, 8'h00, 0, 4'b0010, 2'b00);
        add(0, 0, 1, 0, 8'h44,  3'd4, 8'h44, 8'h00, 0, 4'b1010, 2'b00); // full
        add(0, 0, 1, 0, 8'h55,  3'd4, 8'h44, 8'h00, 0, 4'b1010, 2'b10); // 5 overflow
        add(0, 0, 0, 1, 8'h00,  3'd3, 8'h33, 8'h44, 1, 4'b0010, 2'b10);
        add(0, 0, 0, 1, 8'h00,  3'd2, 8'h22, 8'h33, 1, 4'b0000, 2'b10);
        add(0, 0, 0, 1, 8'h00,  3'd1, 8'h11, 8'h22, 1, 4'b0001, 2'b10);
        add(0, 0, 0, 1, 8'h00,  3'd0, 8'h00, 8'h11, 1, 4'b0101, 2'b10);
        add(0, 0, 0, 1, 8'h00,  3'd0, 8'h00, 8'h11, 0, 4'b0101, 2'b11); // 10 underflow
        add(0, 0, 0, 0, 8'h00,  3'd0, 8'h00, 8'h11, 0, 4'b0101, 2'b11); // sticky
        add(0, 1, 0, 0, 8'h00,  3'd0, 8'h00, 8'h11, 0, 4'b0101, 2'b00); // clear
        add(0, 0, 1, 0, 8'h11,  3'd1, 8'h11, 8'h11, 0, 4'b0001, 2'b00);
        add(0, 0, 1, 0, 8'h22,  3'd2, 8'h22, 8'h11, 0, 4'b0000, 2'b00);
        add(0, 0, 1, 1, 8'hAA,  3'd2, 8'hAA, 8'h22, 1, 4'b0000, 2'b00); // 15 replace
        add(0, 0, 0, 0, 8'h00,  3'd2, 8'hAA, 8'h22, 0, 4'b0000, 2'b00);
        add(0, 1, 0, 0, 8'h00,  3'd0, 8'h00, 8'h22, 0, 4'b0101, 2'b00);
        add(0, 0, 1, 1, 8'h55,  3'd1, 8'h55, 8'h22, 0, 4'b0001, 2'b01); // push+pop empty
        add(0, 0, 1, 0, 8'h66,  3'd2, 8'h66, 8'h22, 0, 4'b0000, 2'b01);
        add(0, 0, 1, 0, 8'h77,  3'd3, 8'h77, 8'h22, 0, 4'b0010, 2'b01); // 20
        add(1, 0, 1, 0, 8'h88,  3'd0, 8'h00, 8'h00, 0, 4'b0101, 2'b00); // rst beats push
        add(0, 0, 0, 1, 8'h00,  3'd0, 8'h00, 8'h00, 0, 4'b0101, 2'b01);
        add(0, 1, 1, 0, 8'h99,  3'd0, 8'h00, 8'h00, 0, 4'b0101, 2'b00); // clear beats push
        add(0, 0, 1, 0, 8'h01,  3'd1, 8'h01, 8'h00, 0, 4'b0001, 2'b00);
        add(0, 0, 1, 0, 8'h02,  3'd2, 8'h02, 8'h00, 0, 4'b0000, 2'b00); // 25
        add(0, 0, 1, 0, 8'h03,  3'd3, 8'h03, 8'h00, 0, 4'b0010, 2'b00);
        add(0, 0, 1, 0, 8'h04,  3'd4, 8'h04, 8'h00, 0, 4'b1010, 2'b00);
        add(0, 0, 1, 1, 8'hBB,  3'd4, 8'hBB, 8'h04, 1, 4'b1010, 2'b00); // replace at full
        add(0, 0, 0, 1, 8'h00,  3'd3, 8'h03, 8'hBB, 1, 4'b0010, 2'b00);
        add(1, 0, 0, 1, 8'h00,  3'd0, 8'h00, 8'h00, 0, 4'b0101, 2'b00); // 30 rst beats pop

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].din);
            chk("count",     i, 32'(count),     32'(vecs[i].cnt));
            chk("top",       i, 32'(top),       32'(vecs[i].top));
            chk("data_out",  i, 32'(data_out),  32'(vecs[i].dout));
            chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
            chk("flags",     i, 32'({full, empty, almost_full, almost_empty}),
                32'(vecs[i].flags));
            chk("errors",    i, 32'({overflow, underflow}), 32'(vecs[i].err));
        end

        // Saturation run: six pushes then six pops from empty, against a
        // queue model; count must never pass 4 or drop below 0.
        step(1, 0, 0, 0, 8'h00);
        exp_ovf  = 1'b0;
        exp_dout = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0, 8'(8'hC0 + i));
            if (model.size() < 4) model.push_back(8'(8'hC0 + i));
            else exp_ovf = 1'b1;
            chk("sat_push_count", 100 + i, 32'(count), 32'(model.size()));
            chk("sat_push_ovf",   100 + i, 32'(overflow), 32'(exp_ovf));
        end
        for (int i = 0; i < 6; i++) begin
            logic exp_v;
            exp_v = 1'b0;
            if (model.size() > 0) begin
                exp_dout = model.pop_back();
                exp_v    = 1'b1;
            end
            step(0, 0, 0, 1, 8'h00);
            chk("sat_pop_count", 200 + i, 32'(count),     32'(model.size()));
            chk("sat_pop_data",  200 + i, 32'(data_out),  32'(exp_dout));
            chk("sat_pop_valid", 200 + i, 32'(out_valid), 32'(exp_v));
        end
        chk("sat_underflow", 300, 32'(underflow), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
